calculadora: RTL and testbench

CALCULADORA -- requirements
Module: calculadora

---
 rtl/calculadora.sv | 101 ++++++++++
 tb/tb_calculadora.sv | 137 +++++++++++++
 2 files changed

// File: rtl/calculadora.sv
// rtl/calculadora.sv - single-cycle unsigned 8-bit calculator with a registered 27-bit result word
//
// Purpose: on every rising clk edge the block samples A, B and op and
// registers the complete result word. The arithmetic, including the
// restoring divider, is fully combinational, so there is no handshake
// and no busy state.
//
// Ports:
//   clk      in   1   clock; all state updates on the rising edge
//   rst      in   1   asynchronous active-low reset; clears S immediately
//   A        in   8   first operand, unsigned
//   B        in   8   second operand, unsigned
//   op       in   2   00 add, 01 subtract, 10 multiply, 11 divide
//   S        out  27  registered result:
//                       [15:0]  magnitude / quotient
//                       [16]    negative flag
//                       [17]    divide-by-zero flag
//                       [25:18] remainder
//                       [26]    reserved, always 0
module calculadora (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  A,
  input  logic [7:0]  B,
  input  logic [1:0]  op,
  output logic [26:0] S
);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  logic [26:0] s_q;
  logic [26:0] s_d;

  logic [8:0]  div_rem;
  logic [8:0]  div_trial;
  logic [7:0]  div_quo;

  // Restoring division array: one row per dividend bit, MSB first. Each row
  // shifts the next dividend bit into the partial remainder and subtracts B
  // when it fits. The remainder always stays below B, so 8 bits hold it;
  // the ninth bit only carries the shifted-out MSB for the compare.
  // With B == 0 every row "fits"; that result is discarded by the
  // divide-by-zero path below.
  always_comb begin
    div_rem   = '0;
    div_trial = '0;
    div_quo   = '0;
    for (int i = 7; i >= 0; i--) begin
      div_trial = {div_rem[7:0], A[i]};
      if (div_trial >= {1'b0, B}) begin
        div_rem    = div_trial - {1'b0, B};
        div_quo[i] = 1'b1;
      end else begin
        div_rem = div_trial;
      end
    end
  end

  // Result word assembly. Every field not explicitly written stays 0,
  // which also keeps the reserved bit 26 clear.
  always_comb begin
    s_d = '0;
    case (op)
      OP_ADD: s_d[15:0] = 16'(A) + 16'(B);
      OP_SUB: begin
        // Sign-magnitude: equal operands take the A >= B branch, so a
        // zero difference never carries the negative flag.
        if (A >= B) begin
          s_d[15:0] = 16'(A - B);
        end else begin
          s_d[15:0] = 16'(B - A);
          s_d[16]   = 1'b1;
        end
      end
      OP_MUL: s_d[15:0] = 16'(A) * 16'(B);
      OP_DIV: begin
        if (B == 8'd0) begin
          s_d[17] = 1'b1;
        end else begin
          s_d[7:0]   = div_quo;
          s_d[25:18] = div_rem[7:0];
        end
      end
      default: s_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s_q <= '0;
    end else begin
      s_q <= s_d;
    end
  end

  assign S = s_q;

endmodule

// File: tb/tb_calculadora.sv
// tb/tb_calculadora.sv - scoreboard testbench for calculadora
module tb_calculadora;

  logic        clk;
  logic        rst;
  logic [7:0]  A;
  logic [7:0]  B;
  logic [1:0]  op;
  logic [26:0] S;

  int tests;
  int fails;
  logic [26:0] exp_q[$];

  calculadora dut (
    .clk (clk),
    .rst (rst),
    .A   (A),
    .B   (B),
    .op  (op),
    .S   (S)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model built from plain integer arithmetic on the field layout.
  function automatic logic [26:0] model(input int a, input int b, input int o);
    int r;
    case (o)
      0: r = a + b;
      1: r = (a >= b) ? (a - b) : ((b - a) + (1 << 16));
      2: r = a * b;
      default: r = (b == 0) ? (1 << 17) : ((a / b) + ((a % b) << 18));
    endcase
    return 27'(r);
  endfunction

  task automatic check(input string name, input logic [26:0] got, input logic [26:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got S=%0d (0x%07h) expected S=%0d (0x%07h)", name, got, got, want, want);
    end
  endtask

  // Drive one operation at the falling edge; the next rising edge loads it.
  task automatic drive(input int a, input int b, input int o, input logic rst_v);
    @(negedge clk);
    rst = rst_v;
    A   = 8'(a);
    B   = 8'(b);
    op  = 2'(o);
    exp_q.push_back(rst_v ? model(a, b, o) : 27'd0);
  endtask

  // Monitor: one result per rising edge, compared once the register settled.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      logic [26:0] e;
      e = exp_q.pop_front();
      check("scoreboard", S, e);
    end
  end

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b0;
    A   = '0;
    B   = '0;
    op  = '0;
    #2;
    check("reset_state", S, 27'd0);

    drive(0, 0, 0, 1'b0);
    drive(200, 100, 0, 1'b1);   // 300
    // Inputs changing between edges must not disturb S.
    @(posedge clk);
    #3;
    A  = 8'd1;
    B  = 8'd1;
    op = 2'd2;
    #1;
    check("hold_between_edges", S, 27'd300);

    drive(5, 9, 1, 1'b1);       // 65540
    drive(9, 9, 1, 1'b1);       // 0
    drive(255, 255, 2, 1'b1);   // 65025
    drive(200, 7, 3, 1'b1);     // 1048604
    drive(13, 0, 3, 1'b1);      // 131072
    drive(255, 255, 0, 1'b1);
    drive(0, 255, 1, 1'b1);
    drive(255, 0, 1, 1'b1);
    drive(255, 1, 3, 1'b1);
    drive(0, 255, 3, 1'b1);
    drive(254, 255, 3, 1'b1);
    drive(0, 0, 3, 1'b1);

    // Asynchronous reset between edges, held over three edges.
    drive(10, 20, 0, 1'b1);     // 30
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("async_reset_immediate", S, 27'd0);
    for (int i = 0; i < 3; i++)
      drive($urandom_range(255), $urandom_range(255), $urandom_range(3), 1'b0);
    drive(3, 4, 2, 1'b1);       // 12 on the first edge after release

    // Reset asserted after an operation is presented but before its edge.
    @(negedge clk);
    A  = 8'd50;
    B  = 8'd60;
    op = 2'd0;
    #2;
    rst = 1'b0;
    exp_q.push_back(27'd0);
    drive(7, 8, 2, 1'b1);       // 56

    for (int i = 0; i < 1000; i++)
      drive($urandom_range(255), $urandom_range(255), $urandom_range(3), 1'b1);

    @(posedge clk);
    #2;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
